// File: rtl/uart_receiver.sv
// uart_receiver: 8E1 UART receive path with 16x oversampling.
// Frame: start(0), 8 data bits LSB first, even parity, stop(1).
// Optional build macro: UART_RX_MAJORITY_EN -- when defined, each bit is the
// 2-of-3 vote of the samples at tick counts 7, 8 and 9 (decision at tick 9);
// otherwise each bit is the single sample at tick count 8.
module uart_receiver #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Rx_EN,
  input  logic       RxD,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR,
  output logic       Rx_BUSY
);

  // Slowest rate (300 baud) has the largest divisor and sizes the counter.
  localparam int DIV_MAX = (CLK_HZ + 8 * 300) / (16 * 300);
  localparam int CW      = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam int BAUD_TAB [8] = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};

  // Decision points of the per-bit tick counter. In START the counter runs
  // from the detecting tick, so the Nth tick after detection sees count N-1.
  // In the later states the counter is cleared at the start decision and
  // wraps every 16 ticks, so every bit is decided at count 15.
`ifdef UART_RX_MAJORITY_EN
  localparam logic [3:0] START_DEC = 4'd8;
`else
  localparam logic [3:0] START_DEC = 4'd7;
`endif
  localparam logic [3:0] BIT_DEC = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Divisor limit table (DIV-1), rounded to nearest.
  logic [CW-1:0] lim_tab [8];
  for (genvar gi = 0; gi < 8; gi++) begin : g_lim
    assign lim_tab[gi] = CW'((CLK_HZ + 8 * BAUD_TAB[gi]) / (16 * BAUD_TAB[gi]) - 1);
  end

  logic [CW-1:0] div_lim;
  logic [CW-1:0] div_cnt_q;
  logic [2:0]    baud_q;
  logic          baud_change;
  logic          tick;

  assign div_lim     = lim_tab[baud_select];
  assign baud_change = (baud_select != baud_q);
  assign tick        = (div_cnt_q == div_lim) && !baud_change;

  // 16x tick generator; restarts from zero whenever the rate changes.
  always_ff @(posedge clk) begin
    baud_q <= baud_select;
    if (reset || baud_change || tick) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + 1'b1;
    end
  end

  logic sync1_q;
  logic sync2_q;
  logic rx_s;

  // Two-flop synchronizer for the asynchronous line, idling high.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= RxD;
      sync2_q <= sync1_q;
    end
  end
  assign rx_s = sync2_q;

  state_t      state_q, state_d;
  logic        armed_q, armed_d;
  logic [3:0]  tick_cnt_q, tick_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        pe_pending_q, pe_pending_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        perr_q, perr_d;
  logic        ferr_q, ferr_d;

  logic [3:0]  dec_cnt;
  logic        decide;
  logic        bit_val;

  assign dec_cnt = (state_q == S_START) ? START_DEC : BIT_DEC;
  assign decide  = tick && (tick_cnt_q == dec_cnt);

`ifdef UART_RX_MAJORITY_EN
  logic s_a_q;
  logic s_b_q;

  // Capture the two samples preceding the decision tick for the vote.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_a_q <= 1'b1;
      s_b_q <= 1'b1;
    end else if (tick) begin
      if (tick_cnt_q == dec_cnt - 4'd2) s_a_q <= rx_s;
      if (tick_cnt_q == dec_cnt - 4'd1) s_b_q <= rx_s;
    end
  end
  assign bit_val = (s_a_q & s_b_q) | (s_a_q & rx_s) | (s_b_q & rx_s);
`else
  assign bit_val = rx_s;
`endif

  // State register plus frame datapath and registered host outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      armed_q      <= 1'b0;
      tick_cnt_q   <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      pe_pending_q <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      pe_pending_q <= pe_pending_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
    end
  end

  // Next-state logic: everything advances only on ticks; disable wins.
  always_comb begin
    state_d      = state_q;
    armed_d      = armed_q;
    tick_cnt_d   = tick_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    pe_pending_d = pe_pending_q;
    if (!Rx_EN) begin
      state_d    = S_IDLE;
      armed_d    = 1'b0;
      tick_cnt_d = '0;
      bit_idx_d  = '0;
    end else if (tick) begin
      tick_cnt_d = tick_cnt_q + 4'd1;
      case (state_q)
        S_IDLE: begin
          tick_cnt_d = '0;
          if (!armed_q) begin
            armed_d = rx_s;
          end else if (!rx_s) begin
            state_d = S_START;
            armed_d = 1'b0;
          end
        end
        S_START: begin
          if (decide) begin
            tick_cnt_d = '0;
            if (!bit_val) begin
              state_d      = S_DATA;
              bit_idx_d    = '0;
              pe_pending_d = 1'b0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (decide) begin
            shift_d[bit_idx_q] = bit_val;
            bit_idx_d          = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_d = S_PARITY;
          end
        end
        S_PARITY: begin
          if (decide) begin
            pe_pending_d = bit_val ^ (^shift_q);
            state_d      = S_STOP;
          end
        end
        S_STOP: begin
          if (decide) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output logic: flags clear on a confirmed start, latch at the stop sample.
  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    if (Rx_EN && decide) begin
      if (state_q == S_START && !bit_val) begin
        perr_d = 1'b0;
        ferr_d = 1'b0;
      end
      if (state_q == S_STOP) begin
        data_d  = shift_q;
        ferr_d  = !bit_val;
        perr_d  = pe_pending_q;
        valid_d = bit_val && !pe_pending_q;
      end
    end
  end

  assign Rx_DATA   = data_q;
  assign Rx_VALID  = valid_q;
  assign Rx_PERROR = perr_q;
  assign Rx_FERROR = ferr_q;
  assign Rx_BUSY   = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver. CLK_HZ is chosen so that 115200 baud
// gives DIV=1 (a tick every clk, making sample timing exact) and 9600 baud
// gives DIV=12.
module tb_uart_receiver;
  localparam int CLK_HZ = 1_843_200;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] baud_select;
  logic       Rx_EN;
  logic       RxD;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_BUSY;

  int checks = 0;
  int fails  = 0;
  int div_now = 1;
  int cyc = 0;
  int valid_cnt = 0, valid_cyc = 0, prev_valid_cyc = 0;
  int busy_rise_cnt = 0, busy_rise_cyc = 0, busy_fall_cyc = 0;
  logic [7:0] valid_data = 8'h00, prev_valid_data = 8'h00;
  logic busy_prev = 1'b0;

  uart_receiver #(.CLK_HZ(CLK_HZ)) dut (
    .clk(clk), .reset(reset), .baud_select(baud_select), .Rx_EN(Rx_EN),
    .RxD(RxD), .Rx_DATA(Rx_DATA), .Rx_VALID(Rx_VALID), .Rx_PERROR(Rx_PERROR),
    .Rx_FERROR(Rx_FERROR), .Rx_BUSY(Rx_BUSY)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observe valid pulses and busy edges away from the active edge.
  always @(negedge clk) begin
    if (Rx_VALID) begin
      prev_valid_cyc  = valid_cyc;
      prev_valid_data = valid_data;
      valid_cyc  = cyc;
      valid_data = Rx_DATA;
      valid_cnt++;
      $display("rx byte 0x%02h at cycle %0d", Rx_DATA, cyc);
    end
    if (Rx_BUSY && !busy_prev) begin
      busy_rise_cnt++;
      busy_rise_cyc = cyc;
    end
    if (!Rx_BUSY && busy_prev) busy_fall_cyc = cyc;
    busy_prev = Rx_BUSY;
  end

  function automatic logic [10:0] mk(input logic [7:0] d, input logic p, input logic s);
    return {s, p, d, 1'b0};
  endfunction

  // Drive the first nbits of a frame, 16*div_now clks per bit; optionally
  // invert one clk at offset goff inside bit gbit.
  task automatic send_bits(input logic [10:0] fr, input int nbits, input int gbit, input int goff);
    for (int j = 0; j < nbits; j++) begin
      for (int k = 0; k < 16 * div_now; k++) begin
        RxD = (j == gbit && k == goff) ? ~fr[j] : fr[j];
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; Rx_EN = 1'b1; RxD = 1'b1; baud_select = 3'd7;
    repeat (4) @(negedge clk);
    checks++; if (Rx_DATA !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", Rx_DATA); end
    checks++; if (Rx_VALID !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", Rx_VALID); end
    checks++; if (Rx_PERROR !== 1'b0) begin fails++; $display("FAIL reset_perr: got %b want 0", Rx_PERROR); end
    checks++; if (Rx_FERROR !== 1'b0) begin fails++; $display("FAIL reset_ferr: got %b want 0", Rx_FERROR); end
    checks++; if (Rx_BUSY !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", Rx_BUSY); end
    reset = 1'b0;
    repeat (32) @(negedge clk);
  endtask

  task automatic test_good_frame();
    int v0, c0;
    v0 = valid_cnt; c0 = cyc;
    send_bits(mk(8'hA5, 1'b0, 1'b1), 11, -1, 0);
    RxD = 1'b1; repeat (32) @(negedge clk);
    checks++; if (Rx_DATA !== 8'hA5) begin fails++; $display("FAIL a5_data: got %h want a5", Rx_DATA); end
    checks++; if (valid_cnt - v0 != 1) begin fails++; $display("FAIL a5_valid_clks: got %0d want 1", valid_cnt - v0); end
    checks++; if (Rx_PERROR !== 1'b0) begin fails++; $display("FAIL a5_perr: got %b want 0", Rx_PERROR); end
    checks++; if (Rx_FERROR !== 1'b0) begin fails++; $display("FAIL a5_ferr: got %b want 0", Rx_FERROR); end
    checks++; if (valid_cyc - c0 != 171 + MAJ) begin fails++; $display("FAIL a5_latency: got %0d want %0d", valid_cyc - c0, 171 + MAJ); end
    checks++; if (busy_rise_cyc - c0 != 3) begin fails++; $display("FAIL a5_busy_rise: got %0d want 3", busy_rise_cyc - c0); end
    checks++; if (busy_fall_cyc != valid_cyc) begin fails++; $display("FAIL a5_busy_fall: got %0d want %0d", busy_fall_cyc, valid_cyc); end
  endtask

  task automatic test_parity_error();
    int v0;
    v0 = valid_cnt;
    send_bits(mk(8'h07, 1'b0, 1'b1), 11, -1, 0);
    RxD = 1'b1; repeat (32) @(negedge clk);
    checks++; if (Rx_DATA !== 8'h07) begin fails++; $display("FAIL pe_data: got %h want 07", Rx_DATA); end
    checks++; if (Rx_PERROR !== 1'b1) begin fails++; $display("FAIL pe_flag: got %b want 1", Rx_PERROR); end
    checks++; if (Rx_FERROR !== 1'b0) begin fails++; $display("FAIL pe_ferr: got %b want 0", Rx_FERROR); end
    checks++; if (valid_cnt != v0) begin fails++; $display("FAIL pe_no_valid: got %0d pulses want 0", valid_cnt - v0); end
    send_bits(mk(8'h3C, 1'b0, 1'b1), 11, -1, 0);
    RxD = 1'b1; repeat (32) @(negedge clk);
    checks++; if (Rx_DATA !== 8'h3C) begin fails++; $display("FAIL pe_next_data: got %h want 3c", Rx_DATA); end
    checks++; if (Rx_PERROR !== 1'b0) begin fails++; $display("FAIL pe_cleared: got %b want 0", Rx_PERROR); end
    checks++; if (valid_cnt - v0 != 1) begin fails++; $display("FAIL pe_next_valid: got %0d want 1", valid_cnt - v0); end
  endtask

  task automatic test_break();
    int v0, r0;
    v0 = valid_cnt; r0 = busy_rise_cnt;
    send_bits(mk(8'h55, 1'b0, 1'b0), 11, -1, 0);
    RxD = 1'b0; repeat (48 * div_now) @(negedge clk);
    checks++; if (Rx_FERROR !== 1'b1) begin fails++; $display("FAIL brk_ferr: got %b want 1", Rx_FERROR); end
    checks++; if (Rx_PERROR !== 1'b0) begin fails++; $display("FAIL brk_perr: got %b want 0", Rx_PERROR); end
    checks++; if (Rx_DATA !== 8'h55) begin fails++; $display("FAIL brk_data: got %h want 55", Rx_DATA); end
    checks++; if (valid_cnt != v0) begin fails++; $display("FAIL brk_no_valid: got %0d pulses want 0", valid_cnt - v0); end
    checks++; if (Rx_BUSY !== 1'b0) begin fails++; $display("FAIL brk_busy_low: got %b want 0", Rx_BUSY); end
    RxD = 1'b1; repeat (32) @(negedge clk);
    checks++; if (busy_rise_cnt - r0 != 1) begin fails++; $display("FAIL brk_no_retrigger: got %0d frames want 1", busy_rise_cnt - r0); end
  endtask

  task automatic test_false_start();
    int v0, r0;
    v0 = valid_cnt; r0 = busy_rise_cnt;
    RxD = 1'b0; repeat (4) @(negedge clk);
    RxD = 1'b1; repeat (40) @(negedge clk);
    checks++; if (busy_rise_cnt - r0 != 1) begin fails++; $display("FAIL fs_busy_pulse: got %0d want 1", busy_rise_cnt - r0); end
    checks++; if (busy_fall_cyc - busy_rise_cyc != 8 + MAJ) begin fails++; $display("FAIL fs_busy_len: got %0d want %0d", busy_fall_cyc - busy_rise_cyc, 8 + MAJ); end
    checks++; if (Rx_BUSY !== 1'b0) begin fails++; $display("FAIL fs_busy_end: got %b want 0", Rx_BUSY); end
    checks++; if (Rx_FERROR !== 1'b1) begin fails++; $display("FAIL fs_ferr_held: got %b want 1", Rx_FERROR); end
    checks++; if (Rx_DATA !== 8'h55) begin fails++; $display("FAIL fs_data_held: got %h want 55", Rx_DATA); end
    checks++; if (valid_cnt != v0) begin fails++; $display("FAIL fs_no_valid: got %0d want 0", valid_cnt - v0); end
  endtask

  task automatic test_enable_drop();
    int v0;
    v0 = valid_cnt;
    send_bits(mk(8'hC3, 1'b0, 1'b1), 5, -1, 0);
    Rx_EN = 1'b0; @(negedge clk);
    checks++; if (Rx_BUSY !== 1'b0) begin fails++; $display("FAIL en_busy: got %b want 0", Rx_BUSY); end
    checks++; if (Rx_DATA !== 8'h55) begin fails++; $display("FAIL en_data: got %h want 55", Rx_DATA); end
    checks++; if (Rx_FERROR !== 1'b0) begin fails++; $display("FAIL en_ferr: got %b want 0", Rx_FERROR); end
    RxD = 1'b1; repeat (16 * 6) @(negedge clk);
    Rx_EN = 1'b1; repeat (32) @(negedge clk);
    checks++; if (valid_cnt != v0) begin fails++; $display("FAIL en_no_valid: got %0d want 0", valid_cnt - v0); end
    send_bits(mk(8'hC3, 1'b0, 1'b1), 11, -1, 0);
    RxD = 1'b1; repeat (32) @(negedge clk);
    checks++; if (Rx_DATA !== 8'hC3) begin fails++; $display("FAIL en_after_data: got %h want c3", Rx_DATA); end
    checks++; if (valid_cnt - v0 != 1) begin fails++; $display("FAIL en_after_valid: got %0d want 1", valid_cnt - v0); end
  endtask

  task automatic test_reset_mid_frame();
    int v0;
    v0 = valid_cnt;
    send_bits(mk(8'h81, 1'b0, 1'b1), 6, -1, 0);
    reset = 1'b1; @(negedge clk);
    checks++; if (Rx_DATA !== 8'h00) begin fails++; $display("FAIL rst_mid_data: got %h want 00", Rx_DATA); end
    checks++; if (Rx_BUSY !== 1'b0) begin fails++; $display("FAIL rst_mid_busy: got %b want 0", Rx_BUSY); end
    checks++; if (Rx_VALID !== 1'b0) begin fails++; $display("FAIL rst_mid_valid: got %b want 0", Rx_VALID); end
    reset = 1'b0; RxD = 1'b1;
    repeat (200) @(negedge clk);
    checks++; if (valid_cnt != v0) begin fails++; $display("FAIL rst_mid_no_valid: got %0d want 0", valid_cnt - v0); end
    checks++; if (Rx_BUSY !== 1'b0) begin fails++; $display("FAIL rst_mid_idle: got %b want 0", Rx_BUSY); end
  endtask

  task automatic test_glitch();
    int v0;
    logic [7:0] exp_data;
    logic exp_perr;
    v0 = valid_cnt;
    exp_data = (MAJ == 1) ? 8'h06 : 8'h04;
    exp_perr = (MAJ == 1) ? 1'b0 : 1'b1;
    // 0x06 with one-clk low glitch at the mid-bit sample of data bit 1.
    send_bits(mk(8'h06, 1'b0, 1'b1), 11, 2, 8);
    RxD = 1'b1; repeat (32) @(negedge clk);
    checks++; if (Rx_DATA !== exp_data) begin fails++; $display("FAIL gl_data: got %h want %h", Rx_DATA, exp_data); end
    checks++; if (Rx_PERROR !== exp_perr) begin fails++; $display("FAIL gl_perr: got %b want %b", Rx_PERROR, exp_perr); end
    checks++; if (valid_cnt - v0 != MAJ) begin fails++; $display("FAIL gl_valid: got %0d want %0d", valid_cnt - v0, MAJ); end
  endtask

  task automatic test_back_to_back();
    int v0, gap;
    baud_select = 3'd3; div_now = 12;
    RxD = 1'b1; repeat (16 * 12 * 2) @(negedge clk);
    v0 = valid_cnt;
    send_bits(mk(8'h00, 1'b0, 1'b1), 11, -1, 0);
    send_bits(mk(8'hFF, 1'b0, 1'b1), 11, -1, 0);
    RxD = 1'b1; repeat (16 * 12 * 2) @(negedge clk);
    gap = valid_cyc - prev_valid_cyc;
    checks++; if (valid_cnt - v0 != 2) begin fails++; $display("FAIL b2b_count: got %0d want 2", valid_cnt - v0); end
    checks++; if (prev_valid_data !== 8'h00) begin fails++; $display("FAIL b2b_first: got %h want 00", prev_valid_data); end
    checks++; if (valid_data !== 8'hFF) begin fails++; $display("FAIL b2b_second: got %h want ff", valid_data); end
    checks++; if (gap < 175 * 12 || gap > 177 * 12) begin fails++; $display("FAIL b2b_gap: got %0d clks want %0d +/- 12", gap, 176 * 12); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_error();
    test_break();
    test_false_start();
    test_enable_drop();
    test_reset_mid_frame();
    test_glitch();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule
